// File: rtl/muldiv_seq.sv
// muldiv_seq -- iterative multiply/divide sequencer that owns the HI/LO pair.
//
// One shared 2*WIDTH accumulator and one operand register. A multiply runs
// shift-add steps. A divide runs restoring subtract/shift steps. Both use
// operand magnitudes, and the sign is fixed up in the FIX state before
// HI/LO are written.
//
// Optional feature, enabled by defining MULDIV_DIV0_EXC_EN:
//   A DIV/DIVU with b==0 is short-circuited straight to DONE and pulses div0.
//   HI/LO are left unchanged.
//   Without the macro, div0 is tied low and a divide by zero runs the full
//   sequence.
//
// Ports:
//   clk, rst          clock; asynchronous active-low reset
//   start, op, a, b   one-cycle request (op: 00 MULT, 01 MULTU, 10 DIV, 11 DIVU)
//   cancel            abort the operation in CALC/FIX; HI/LO are untouched
//   hi_we, lo_we      MTHI/MTLO strobes, data on wdata
//   busy, done, div0  registered status outputs
//   hi, lo            architectural HI/LO
module muldiv_seq #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [1:0]       op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cancel,
  input  logic             hi_we,
  input  logic             lo_we,
  input  logic [WIDTH-1:0] wdata,
  output logic             busy,
  output logic             done,
  output logic             div0,
  output logic [WIDTH-1:0] hi,
  output logic [WIDTH-1:0] lo
);
  localparam int W = WIDTH;
  localparam logic [5:0] LAST = 6'(WIDTH - 1);

  typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX, S_DONE} state_t;

  state_t         state_q, state_d;
  logic [5:0]     cnt_q, cnt_d;
  logic           is_div_q, is_div_d;
  logic           sgn_quo_q, sgn_quo_d;   // negate product / quotient
  logic           sgn_rem_q, sgn_rem_d;   // negate remainder (dividend sign)
  logic [W-1:0]   opnd_q, opnd_d;         // multiplicand or divisor magnitude
  logic [2*W-1:0] acc_q, acc_d;
  logic           busy_q, busy_d;
  logic           done_q, done_d;
  logic [W-1:0]   hi_q, hi_d, lo_q, lo_d;
`ifdef MULDIV_DIV0_EXC_EN
  logic           div0_q, div0_d;
`endif

  // Operand decode at acceptance. Unsigned ops use the raw values.
  logic         neg_a, neg_b;
  logic [W-1:0] mag_a, mag_b;
  assign neg_a = ~op[0] & a[W-1];
  assign neg_b = ~op[0] & b[W-1];
  assign mag_a = neg_a ? -a : a;
  assign mag_b = neg_b ? -b : b;

  // Multiply step: conditionally add into the upper half, then shift the
  // whole accumulator right. The sum keeps the carry, which becomes the new MSB.
  logic [W:0] mul_sum;
  assign mul_sum = {1'b0, acc_q[2*W-1:W]} + {1'b0, (opnd_q & {W{acc_q[0]}})};

  // Restoring divide step: upper half is the partial remainder, and the lower
  // half shifts the dividend out and the quotient in. The extra top bit of the
  // trial value is the borrow.
  logic [W+1:0] div_trial;
  assign div_trial = {1'b0, acc_q[2*W-1:W-1]} - {2'b00, opnd_q};

  // Sign fix-up. A zero remainder stays zero, because -0 == 0.
  logic [2*W-1:0] prod;
  logic [W-1:0]   quo, rem;
  assign prod = sgn_quo_q ? -acc_q : acc_q;
  assign quo  = sgn_quo_q ? -acc_q[W-1:0] : acc_q[W-1:0];
  assign rem  = sgn_rem_q ? -acc_q[2*W-1:W] : acc_q[2*W-1:W];

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    is_div_d  = is_div_q;
    sgn_quo_d = sgn_quo_q;
    sgn_rem_d = sgn_rem_q;
    opnd_d    = opnd_q;
    acc_d     = acc_q;
    busy_d    = busy_q;
    done_d    = 1'b0;
`ifdef MULDIV_DIV0_EXC_EN
    div0_d    = 1'b0;
`endif
    // MTHI/MTLO land in any state. The FIX commit below overrides them.
    hi_d = hi_we ? wdata : hi_q;
    lo_d = lo_we ? wdata : lo_q;

    case (state_q)
      S_IDLE: if (start) begin
        is_div_d  = op[1];
        sgn_quo_d = neg_a ^ neg_b;
        sgn_rem_d = neg_a;
        opnd_d    = op[1] ? mag_b : mag_a;
        acc_d     = {{W{1'b0}}, (op[1] ? mag_a : mag_b)};
        cnt_d     = '0;
`ifdef MULDIV_DIV0_EXC_EN
        if (op[1] && (b == '0)) begin
          state_d = S_DONE;
          done_d  = 1'b1;
          div0_d  = 1'b1;
        end else begin
          state_d = S_CALC;
          busy_d  = 1'b1;
        end
`else
        state_d = S_CALC;
        busy_d  = 1'b1;
`endif
      end
      S_CALC: if (cancel) begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end else begin
        if (is_div_q)
          acc_d = div_trial[W+1] ? {acc_q[2*W-2:0], 1'b0}
                                 : {div_trial[W-1:0], acc_q[W-2:0], 1'b1};
        else
          acc_d = {mul_sum, acc_q[W-1:1]};
        cnt_d = cnt_q + 6'd1;
        if (cnt_q == LAST) state_d = S_FIX;
      end
      S_FIX: begin
        state_d = cancel ? S_IDLE : S_DONE;
        busy_d  = 1'b0;
        if (!cancel) begin
          done_d = 1'b1;
          if (is_div_q) begin
            hi_d = rem;
            lo_d = quo;
          end else begin
            hi_d = prod[2*W-1:W];
            lo_d = prod[W-1:0];
          end
        end
      end
      default: state_d = S_IDLE;   // S_DONE: one-cycle done pulse
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      is_div_q  <= 1'b0;
      sgn_quo_q <= 1'b0;
      sgn_rem_q <= 1'b0;
      opnd_q    <= '0;
      acc_q     <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hi_q      <= '0;
      lo_q      <= '0;
`ifdef MULDIV_DIV0_EXC_EN
      div0_q    <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      is_div_q  <= is_div_d;
      sgn_quo_q <= sgn_quo_d;
      sgn_rem_q <= sgn_rem_d;
      opnd_q    <= opnd_d;
      acc_q     <= acc_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
`ifdef MULDIV_DIV0_EXC_EN
      div0_q    <= div0_d;
`endif
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign hi   = hi_q;
  assign lo   = lo_q;
`ifdef MULDIV_DIV0_EXC_EN
  assign div0 = div0_q;
`else
  assign div0 = 1'b0;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// tb_muldiv_seq -- directed and random checks of muldiv_seq against an
// arithmetic reference model (64-bit integer multiply/divide plus the
// divide-by-zero rules).
module tb_muldiv_seq;
  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        start = 1'b0, cancel = 1'b0, hi_we = 1'b0, lo_we = 1'b0;
  logic [1:0]  op = 2'b00;
  logic [31:0] a = '0, b = '0, wdata = '0;
  logic        busy, done, div0;
  logic [31:0] hi, lo;

  int checks = 0;
  int failures = 0;
  logic [31:0] m_hi = '0, m_lo = '0;   // model copy of HI/LO

  muldiv_seq #(.WIDTH(32)) dut (
    .clk(clk), .rst(rst), .start(start), .op(op), .a(a), .b(b),
    .cancel(cancel), .hi_we(hi_we), .lo_we(lo_we), .wdata(wdata),
    .busy(busy), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk); #1;
  endtask

  // Reference result. Returns 1 when the op takes the div0 short-circuit.
  function automatic bit model(input logic [1:0] o, input logic [31:0] x, y,
                               output logic [31:0] eh, output logic [31:0] el);
    longint sx, sy, p, q, r;
    logic [63:0] up;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    eh = m_hi; el = m_lo;
`ifdef MULDIV_DIV0_EXC_EN
    if (o[1] && y == 0) return 1'b1;
`endif
    case (o)
      2'b00: begin p = sx * sy; up = p; {eh, el} = up; end
      2'b01: begin up = {32'b0, x} * {32'b0, y}; {eh, el} = up; end
      2'b10: if (y == 0) begin
               el = (sx >= 0) ? 32'hFFFF_FFFF : 32'h0000_0001; eh = x;
             end else begin
               q = sx / sy; r = sx % sy; el = q[31:0]; eh = r[31:0];
             end
      default: if (y == 0) begin el = 32'hFFFF_FFFF; eh = x; end
               else begin el = x / y; eh = x % y; end
    endcase
    return 1'b0;
  endfunction

  // Issue one op. Optionally assert cancel with start, or pulse hi_we/lo_we
  // with 0xAAAA in cycle wr_at. Then check latency, busy, and the result.
  task automatic run_op(input string tag, input logic [1:0] o, input logic [31:0] x, y,
                        input logic cx, input int wr_at);
    int n; logic busy_ok; bit z; logic [31:0] eh, el;
    z = model(o, x, y, eh, el);
    op = o; a = x; b = y; start = 1'b1; cancel = cx;
    tick();
    start = 1'b0; cancel = 1'b0; n = 1; busy_ok = 1'b1;
    while (done !== 1'b1 && n < 40) begin
      if (busy !== 1'b1) busy_ok = 1'b0;
      hi_we = (n == wr_at); lo_we = (n == wr_at); wdata = 32'h0000_AAAA;
      tick();
      n++;
    end
    hi_we = 1'b0; lo_we = 1'b0;
    check({tag, " latency"}, n, z ? 1 : 34);
    check({tag, " busy during op"}, busy_ok, 1'b1);
    check({tag, " busy at done"}, busy, 1'b0);
    check({tag, " div0"}, div0, z);
    check({tag, " hi"}, hi, eh);
    check({tag, " lo"}, lo, el);
    m_hi = eh; m_lo = el;
    tick();   // done cycle -> IDLE; next start is accepted right away
  endtask

  initial begin
    int n; logic saw_done;
    logic [1:0] ro; logic [31:0] ra, rb;

    // Reset state
    repeat (3) tick();
    check("rst busy", busy, 1'b0);
    check("rst done", done, 1'b0);
    check("rst div0", div0, 1'b0);
    check("rst hi", hi, 32'h0);
    check("rst lo", lo, 32'h0);
    rst = 1'b1;
    tick();

    // Directed cases
    run_op("multu max", 2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    check("multu max hi const", hi, 32'hFFFF_FFFE);
    check("multu max lo const", lo, 32'h0000_0001);
    run_op("mult -3*7", 2'b00, -32'sd3, 32'd7, 1'b0, 0);
    run_op("div -7/2", 2'b10, -32'sd7, 32'd2, 1'b0, 0);
    run_op("div min/-1", 2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 0);
    run_op("divu 100/7", 2'b11, 32'd100, 32'd7, 1'b0, 0);
    run_op("div -8/2 rem0", 2'b10, -32'sd8, 32'd2, 1'b0, 0);
    run_op("start+cancel", 2'b00, 32'd12345, -32'sd99, 1'b1, 0);
    run_op("mtx in calc", 2'b01, 32'hDEAD_BEEF, 32'h1234_5678, 1'b0, 5);
    run_op("mtx on fix", 2'b00, 32'h7FFF_FFFF, 32'h8000_0000, 1'b0, 33);
    run_op("divu by 0", 2'b11, 32'd5, 32'd0, 1'b0, 0);
    run_op("div neg by 0", 2'b10, -32'sd9, 32'd0, 1'b0, 0);

    // MTLO in IDLE
    lo_we = 1'b1; wdata = 32'h5A5A_0001; tick(); lo_we = 1'b0; m_lo = 32'h5A5A_0001;
    check("mtlo idle", lo, m_lo);

    // MTHI, then cancel a MULT in cycle 10. A start in cycle 5 is ignored.
    hi_we = 1'b1; wdata = 32'h0000_1234; tick(); hi_we = 1'b0; m_hi = 32'h0000_1234;
    check("mthi", hi, m_hi);
    op = 2'b00; a = 32'd77; b = 32'd88; start = 1'b1; tick(); start = 1'b0; n = 1;
    while (n < 10) begin
      start = (n == 5); if (n == 5) begin op = 2'b11; a = 32'd100; b = 32'd7; end
      tick(); n++;
    end
    start = 1'b0;
    check("busy before cancel", busy, 1'b1);
    cancel = 1'b1; tick(); cancel = 1'b0;
    check("busy after cancel", busy, 1'b0);
    saw_done = 1'b0;
    repeat (40) begin tick(); if (done === 1'b1) saw_done = 1'b1; end
    check("no done after cancel", saw_done, 1'b0);
    check("hi after cancel", hi, m_hi);
    check("lo after cancel", lo, m_lo);

    // Asynchronous reset in the middle of CALC
    op = 2'b01; a = 32'd3; b = 32'd4; start = 1'b1; tick(); start = 1'b0;
    repeat (8) tick();
    rst = 1'b0; #1;
    check("rst mid busy", busy, 1'b0);
    check("rst mid done", done, 1'b0);
    check("rst mid hi", hi, 32'h0);
    check("rst mid lo", lo, 32'h0);
    m_hi = '0; m_lo = '0;
    tick(); rst = 1'b1; tick();

    // Random ops
    for (int i = 0; i < 24; i++) begin
      ro = 2'($urandom_range(0, 3));
      ra = $urandom;
      rb = $urandom;
      case ($urandom_range(0, 7))
        0: rb = 32'h0;
        1: rb = 32'hFFFF_FFFF;
        2: ra = 32'h8000_0000;
        3: rb = 32'($urandom_range(1, 9));
        default: ;
      endcase
      run_op($sformatf("rand%0d op%0d", i, ro), ro, ra, rb, 1'b0, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog
  initial begin
    #500000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Iterative multiply/divide sequencer owning the HI/LO register pair for the multicycle CPU. The main controller issues MULT/MULTU/DIV/DIVU with a one-cycle start and holds its final state while `busy` is high. This block then runs a shared 32-step shift/add-subtract datapath, applies sign correction, and commits the result to HI/LO. It also services MTHI/MTLO writes and exception-driven cancellation.

## Interface
Parameters:
- `WIDTH`, 32: operand width; HI/LO are `WIDTH` bits each, and the iteration count equals `WIDTH`.

Ports:
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous reset, active-low; one clock domain.
- `start`  in  1  one-cycle operation request; accepted only in IDLE.
- `op`  in  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; sampled with `start`.
- `a`  in  WIDTH  Rs value: multiplicand or dividend; sampled with `start`.
- `b`  in  WIDTH  Rt value: multiplier or divisor; sampled with `start`.
- `cancel`  in  1  abort the operation in flight (exception); HI/LO are untouched.
- `hi_we`, `lo_we`  in  1  MTHI/MTLO write strobes.
- `wdata`  in  WIDTH  MTHI/MTLO data.
- `busy`  out  1  high from the cycle after acceptance through the FIX cycle.
- `done`  out  1  one-cycle pulse; HI/LO hold the new result in this cycle.
- `div0`  out  1  one-cycle pulse; exists only with `MULDIV_DIV0_EXC_EN`.
- `hi`, `lo`  out  WIDTH  architectural HI/LO registers.

## Operation
- States: IDLE, CALC, FIX, DONE.
- IDLE:
  - `start` latches `op`, a, b, sign flags, and operand magnitudes (unsigned ops use raw values).
  - Clears the 6-bit step counter. Next state: CALC.
- CALC:
  - Mult: one shift-add step per cycle on a 2*WIDTH accumulator.
  - Div: one restoring subtract/shift step per cycle.
  - After step WIDTH-1 (counter == WIDTH-1), next state is FIX.
- FIX:
  - Mult: negate the 64-bit product when the operand signs differ (signed ops only). HI = upper half, LO = lower half.
  - Div: negate the quotient when the signs differ; the remainder takes the dividend's sign. LO = quotient, HI = remainder.
  - Next state: DONE.
- DONE: `done`=1, then IDLE.
- Divide boundary cases:
  - -2^31 / -1 gives LO=0x80000000, HI=0.
  - A remainder of zero is never negated to a non-zero value.
- `start` while not in IDLE is ignored; no queueing.
- `cancel` in CALC or FIX returns to IDLE next cycle. No `done`, no HI/LO write. `cancel` in IDLE or DONE has no effect.
- `start` and `cancel` in the same IDLE cycle: `start` wins.
- `hi_we`/`lo_we`:
  - Write on the next edge in any state.
  - If the same edge is the FIX commit edge, the FIX result wins.
  - A write in CALC is overwritten at FIX.
- Reset: state=IDLE, `busy`=0, `done`=0, `div0`=0, `hi`=0, `lo`=0, counter=0, all datapath registers=0.

## Timing
- Accept at edge 0.
- `busy`=1 from cycle 1 through cycle WIDTH+1 (CALC = cycles 1..WIDTH, FIX = cycle WIDTH+1).
- `done`=1 in cycle WIDTH+2, with `busy`=0 in that cycle.
- Start-to-done latency: 34 cycles for WIDTH=32.
- A new `start` can be accepted in the cycle after `done`.
- `busy` and `done` are registered outputs; no combinational path from inputs.
- The controller samples HI/LO in or after the `done` cycle.

## Configuration
- `MULDIV_DIV0_EXC_EN` defined:
  - DIV/DIVU with b==0 skips CALC: IDLE -> DONE.
  - `div0`=1 and `done`=1 in cycle 1; `busy` stays 0; HI/LO unchanged. Latency is 1 cycle.
- Undefined:
  - `div0` is absent (tied 0 if the port is kept for wiring); divide-by-zero runs the full 34 cycles.
  - DIVU gives LO=0xFFFFFFFF, HI=a.
  - DIV gives LO=0xFFFFFFFF if a>=0, else 0x00000001; HI=a.

## Test plan
- MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> `done` at cycle 34, HI=0xFFFFFFFE, LO=0x00000001.
- MULT a=-3, b=7 -> HI=0xFFFFFFFF, LO=0xFFFFFFEB; DIV a=-7, b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- DIV a=0x80000000, b=0xFFFFFFFF -> LO=0x80000000, HI=0; DIVU a=100, b=7 -> LO=14, HI=2.
- `cancel` at cycle 10 of MULT after MTHI 0x1234 -> `busy` low at cycle 11, no `done`, HI stays 0x1234; a `start` issued mid-operation is ignored.
- `hi_we` with 0xAAAA on the FIX edge -> HI holds the product, not 0xAAAA; `rst` low mid-CALC -> all outputs 0 immediately.
- DIVU b=0, a=5 -> with the macro: `div0` and `done` at cycle 1, HI/LO unchanged; without it: `done` at cycle 34, LO=0xFFFFFFFF, HI=5.
